srl_fifo: RTL and testbench
===========================

Name: srl_fifo

Overview:
- Parametrised synchronous FIFO built on an addressable shift-register store: writes shift data in at position 0, and reads take the oldest entry at tap address COUNT-1.
- Successor to the single-bit 32-deep addressable shift primitive, generalised to WIDTH bits and 2**ADDR_WIDTH depth.
- Adds occupancy tracking, full/empty/half-full flags and error pulses.
- Buffers bytes between the UART macros and the PicoBlaze port interface.

Parameters:
- WIDTH, 8, data width in bits (1..32).
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (1..5, i.e. depth 2..32).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- DIN  input  WIDTH  write data.
- WR  input  1  write strobe, one entry per cycle while high.
- RD  input  1  read strobe; pops the entry currently on DOUT.
- DOUT  output  WIDTH  oldest entry (first-word fall-through, combinational from store and COUNT).
- COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- EMPTY  output  1  COUNT == 0.
- FULL  output  1  COUNT == DEPTH.
- HALF_FULL  output  1  COUNT >= DEPTH/2.
- OVERFLOW  output  1  one-cycle pulse: write rejected.
- UNDERFLOW  output  1  one-cycle pulse: read rejected.

Behaviour:
- Store: DEPTH x WIDTH shift register. On an accepted write, store <= {store[DEPTH-2:0], DIN}, so the entry at position k is the k-th newest.
- Store contents are not cleared by RST. Time-zero contents are all zero.
- DOUT = store[COUNT-1] when COUNT >= 1. DOUT is don't-care when EMPTY; the bench must not check it.
- Write accepted when WR && (!FULL || RD). Read accepted when RD && !EMPTY.
- Per-cycle update, registered:
  - Write only: shift, COUNT+1.
  - Read only: no shift, COUNT-1.
  - Write and read both accepted: shift, COUNT unchanged. DOUT then shows the next-oldest entry, because the tap index is unchanged while data moved one position.
  - Neither: hold.
- WR while FULL and !RD: write ignored; OVERFLOW=1 in the next cycle for one cycle. COUNT and store unchanged.
- WR && RD while FULL: both accepted, no OVERFLOW, COUNT stays DEPTH.
- RD while EMPTY: read ignored; UNDERFLOW=1 in the next cycle for one cycle.
- WR && RD while EMPTY: write accepted (COUNT becomes 1), read ignored, UNDERFLOW pulses. There is no bypass of DIN to DOUT.
- Latency: data written in cycle n is visible on DOUT in cycle n+1 if the FIFO was empty. Flags and COUNT are registered and valid in the cycle after the causing edge.
- Reset, including mid-operation: COUNT=0, EMPTY=1, FULL=0, HALF_FULL=0, OVERFLOW=0, UNDERFLOW=0. RST has priority over WR/RD in the same cycle; neither is accepted and no error pulses are generated.
- Flags are decoded from the registered COUNT (EMPTY, FULL, HALF_FULL) or registered directly (OVERFLOW, UNDERFLOW). There are no combinational paths from WR/RD to any flag.
- COUNT never wraps: it saturates logically at 0 and DEPTH through the acceptance rules above.
- DEPTH=2 edge case: HALF_FULL asserts at COUNT>=1.

Test Plan:
- Defaults. RST, then write 0x11,0x22,0x33 on consecutive cycles.
  - Required: DOUT=0x11 and COUNT=3 after the third edge.
  - Three RD cycles return 0x11, 0x22, 0x33 in that order; then EMPTY=1, COUNT=0.
- Write 16 entries 0x00..0x0F.
  - Required: HALF_FULL rises on the edge where COUNT becomes 8; FULL=1 at COUNT=16.
  - A 17th WR gives a single-cycle OVERFLOW pulse; COUNT stays 16 and DOUT stays 0x00.
- With FULL, assert WR(0xAA) and RD together.
  - Required: COUNT stays 16, no OVERFLOW, DOUT becomes 0x01.
  - Draining all entries yields 0x01..0x0F then 0xAA.
- From EMPTY, pulse RD alone.
  - Required: UNDERFLOW=1 for exactly one cycle, COUNT=0.
- From EMPTY, assert RD and WR(0x5C) together.
  - Required: UNDERFLOW pulses, COUNT=1, DOUT=0x5C.
- With COUNT=5, assert RST together with WR.
  - Required: COUNT=0, EMPTY=1, all flags zero.
  - Then write 0x77: DOUT=0x77 next cycle.
- Repeat the first two scenarios with WIDTH=1, ADDR_WIDTH=5 (depth 32) and WIDTH=32, ADDR_WIDTH=1 (depth 2).

Source files
------------

// File: rtl/srl_fifo.sv
// Purpose: synchronous FIFO on an addressable shift-register store (write shifts in at 0, read taps COUNT-1).
// Latency: a write into an empty FIFO shows on DOUT one cycle later; COUNT and flags are registered.
// Backpressure: writes to a full FIFO are dropped (OVERFLOW pulse) unless a read frees a slot in the same cycle;
//               reads of an empty FIFO are dropped (UNDERFLOW pulse).
module srl_fifo #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  WR,
    input  logic                  RD,
    output logic [WIDTH-1:0]      DOUT,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  HALF_FULL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] HALF_CNT  = (ADDR_WIDTH + 1)'(DEPTH / 2);
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_TAP = ADDR_WIDTH'(1);

    // Position k holds the k-th newest entry; the store is never cleared.
    logic [DEPTH-1:0][WIDTH-1:0] store;
    logic [ADDR_WIDTH:0]         count_q;
    logic                        overflow_q;
    logic                        underflow_q;
    logic                        empty;
    logic                        full;
    logic                        wr_ok;
    logic                        rd_ok;
    logic [ADDR_WIDTH-1:0]       tap;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // A read frees the slot a simultaneous write needs, so a full FIFO still accepts WR with RD.
    assign wr_ok = WR && (!full || RD) && !RST;
    assign rd_ok = RD && !empty && !RST;

    // Oldest entry sits at COUNT-1; at COUNT=DEPTH the low bits wrap to DEPTH-1 as required.
    assign tap  = count_q[ADDR_WIDTH-1:0] - ONE_TAP;
    assign DOUT = store[tap];

    assign COUNT     = count_q;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign HALF_FULL = (count_q >= HALF_CNT);
    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;

    // Shift new data in at position 0 on every accepted write, independent of reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            store <= {store[DEPTH-2:0], DIN};
        end
    end

    // Occupancy: a simultaneous accepted read and write leaves it unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Error pulses reflect the previous cycle's rejected strobes only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= WR && full && !RD;
            underflow_q <= RD && empty;
        end
    end

endmodule

// File: tb/tb_srl_fifo.sv
// Bench for srl_fifo: three parameterisations share stimulus, one selected at a time.
// Expected values come from a queue model of FIFO semantics.
// Outputs are sampled 1 time unit after the rising edge.
module tb_srl_fifo;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        wr  = 1'b0;
    logic        rd  = 1'b0;
    logic [31:0] din = '0;
    int          sel = 0;

    int          checks = 0;
    int          errors = 0;
    int          cur_depth;
    logic [31:0] mask;

    logic [31:0] q[$];
    logic        e_ovf = 1'b0;
    logic        e_unf = 1'b0;

    always #5 CLK = ~CLK;

    // Instance 0: WIDTH 8, depth 16
    logic [7:0] dout0; logic [4:0] cnt0; logic em0, fu0, hf0, ov0, un0;
    srl_fifo #(.WIDTH(8), .ADDR_WIDTH(4)) u0 (
        .CLK(CLK), .RST(rst), .DIN(din[7:0]), .WR(wr && sel == 0), .RD(rd && sel == 0),
        .DOUT(dout0), .COUNT(cnt0), .EMPTY(em0), .FULL(fu0), .HALF_FULL(hf0),
        .OVERFLOW(ov0), .UNDERFLOW(un0));

    // Instance 1: WIDTH 1, depth 32
    logic [0:0] dout1; logic [5:0] cnt1; logic em1, fu1, hf1, ov1, un1;
    srl_fifo #(.WIDTH(1), .ADDR_WIDTH(5)) u1 (
        .CLK(CLK), .RST(rst), .DIN(din[0:0]), .WR(wr && sel == 1), .RD(rd && sel == 1),
        .DOUT(dout1), .COUNT(cnt1), .EMPTY(em1), .FULL(fu1), .HALF_FULL(hf1),
        .OVERFLOW(ov1), .UNDERFLOW(un1));

    // Instance 2: WIDTH 32, depth 2
    logic [31:0] dout2; logic [1:0] cnt2; logic em2, fu2, hf2, ov2, un2;
    srl_fifo #(.WIDTH(32), .ADDR_WIDTH(1)) u2 (
        .CLK(CLK), .RST(rst), .DIN(din), .WR(wr && sel == 2), .RD(rd && sel == 2),
        .DOUT(dout2), .COUNT(cnt2), .EMPTY(em2), .FULL(fu2), .HALF_FULL(hf2),
        .OVERFLOW(ov2), .UNDERFLOW(un2));

    logic [31:0] dout_s;
    logic [5:0]  cnt_s;
    logic        em_s, fu_s, hf_s, ov_s, un_s;

    always_comb begin
        dout_s = {24'b0, dout0}; cnt_s = {1'b0, cnt0};
        em_s = em0; fu_s = fu0; hf_s = hf0; ov_s = ov0; un_s = un0;
        if (sel == 1) begin
            dout_s = {31'b0, dout1}; cnt_s = cnt1;
            em_s = em1; fu_s = fu1; hf_s = hf1; ov_s = ov1; un_s = un1;
        end else if (sel == 2) begin
            dout_s = dout2; cnt_s = {4'b0, cnt2};
            em_s = em2; fu_s = fu2; hf_s = hf2; ov_s = ov2; un_s = un2;
        end
    end

    // One clock with the given strobes; the queue model advances on the same edge.
    task automatic drive(input logic r, input logic w, input logic rdi, input logic [31:0] d);
        bit was_full, was_empty;
        rst = r; wr = w; rd = rdi; din = d;
        @(posedge CLK);
        if (r) begin
            q.delete(); e_ovf = 1'b0; e_unf = 1'b0;
        end else begin
            was_full  = (q.size() == cur_depth);
            was_empty = (q.size() == 0);
            e_ovf = w && was_full && !rdi;
            e_unf = rdi && was_empty;
            if (rdi && !was_empty) void'(q.pop_front());
            if (w && (!was_full || rdi)) q.push_back(d & mask);
        end
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 32'h5);
        checks++; if (cnt_s !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt_s); end
        checks++; if (em_s !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", em_s); end
        checks++; if ({fu_s, hf_s, ov_s, un_s} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got full/half/ovf/unf=%b want 0000", {fu_s, hf_s, ov_s, un_s}); end
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, vals[i]);
        checks++; if (cnt_s !== 6'(q.size())) begin errors++; $display("FAIL basic_count got %0d want %0d", cnt_s, q.size()); end
        checks++; if (dout_s !== q[0]) begin errors++; $display("FAIL basic_dout got %h want %h", dout_s, q[0]); end
        for (int i = 0; i < 3; i++) begin
            if (q.size() != 0) begin
                checks++; if (dout_s !== q[0]) begin errors++; $display("FAIL basic_read%0d got %h want %h", i, dout_s, q[0]); end
            end
            drive(0, 0, 1, 0);
        end
        checks++; if (em_s !== 1'b1 || cnt_s !== 6'd0) begin errors++;
            $display("FAIL basic_drained got empty=%b count=%0d want empty=1 count=0", em_s, cnt_s); end
    endtask

    task automatic test_fill();
        drive(1, 0, 0, 0);
        for (int i = 0; i < cur_depth; i++) begin
            drive(0, 1, 0, 32'(i));
            checks++; if (hf_s !== (q.size() >= cur_depth / 2)) begin errors++;
                $display("FAIL fill_half at count %0d got %b", q.size(), hf_s); end
            checks++; if (fu_s !== (q.size() == cur_depth)) begin errors++;
                $display("FAIL fill_full at count %0d got %b", q.size(), fu_s); end
        end
        drive(0, 1, 0, 32'hEE);
        checks++; if (ov_s !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", ov_s); end
        checks++; if (cnt_s !== 6'(cur_depth)) begin errors++; $display("FAIL fill_ovf_count got %0d want %0d", cnt_s, cur_depth); end
        checks++; if (dout_s !== 32'h0) begin errors++; $display("FAIL fill_ovf_dout got %h want 0", dout_s); end
        drive(0, 0, 0, 0);
        checks++; if (ov_s !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got %b want 0", ov_s); end
    endtask

    task automatic test_full_rw();
        drive(1, 0, 0, 0);
        for (int i = 0; i < cur_depth; i++) drive(0, 1, 0, 32'(i));
        drive(0, 1, 1, 32'hAA);
        checks++; if (cnt_s !== 6'(cur_depth)) begin errors++; $display("FAIL fullrw_count got %0d want %0d", cnt_s, cur_depth); end
        checks++; if (ov_s !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b want 0", ov_s); end
        checks++; if (dout_s !== q[0]) begin errors++; $display("FAIL fullrw_dout got %h want %h", dout_s, q[0]); end
        for (int i = 0; i < cur_depth; i++) begin
            checks++; if (dout_s !== q[0]) begin errors++; $display("FAIL fullrw_drain%0d got %h want %h", i, dout_s, q[0]); end
            drive(0, 0, 1, 0);
        end
        checks++; if (em_s !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b want 1", em_s); end
    endtask

    task automatic test_underflow();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        checks++; if (un_s !== 1'b1 || cnt_s !== 6'd0) begin errors++;
            $display("FAIL underflow got unf=%b count=%0d want unf=1 count=0", un_s, cnt_s); end
        drive(0, 0, 0, 0);
        checks++; if (un_s !== 1'b0) begin errors++; $display("FAIL underflow_pulse got %b want 0", un_s); end
    endtask

    task automatic test_underflow_wr();
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 32'h5C);
        checks++; if (un_s !== 1'b1) begin errors++; $display("FAIL unfwr_unf got %b want 1", un_s); end
        checks++; if (cnt_s !== 6'd1) begin errors++; $display("FAIL unfwr_count got %0d want 1", cnt_s); end
        checks++; if (dout_s !== (32'h5C & mask)) begin errors++; $display("FAIL unfwr_dout got %h want %h", dout_s, 32'h5C & mask); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 32'(i + 3));
        drive(1, 1, 0, 32'h99);
        checks++; if (cnt_s !== 6'd0 || em_s !== 1'b1) begin errors++;
            $display("FAIL rstmid got count=%0d empty=%b want 0/1", cnt_s, em_s); end
        checks++; if ({fu_s, hf_s, ov_s, un_s} !== 4'b0) begin errors++;
            $display("FAIL rstmid_flags got %b want 0000", {fu_s, hf_s, ov_s, un_s}); end
        drive(0, 1, 0, 32'h77);
        checks++; if (dout_s !== (32'h77 & mask)) begin errors++; $display("FAIL rstmid_dout got %h want %h", dout_s, 32'h77 & mask); end
    endtask

    task automatic test_random();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom);
            checks++;
            if (cnt_s !== 6'(q.size()) || em_s !== (q.size() == 0) || fu_s !== (q.size() == cur_depth) ||
                hf_s !== (q.size() >= cur_depth / 2) || ov_s !== e_ovf || un_s !== e_unf ||
                (q.size() != 0 && dout_s !== q[0])) begin
                errors++;
                $display("FAIL random cyc %0d got cnt=%0d e/f/h/o/u=%b%b%b%b%b dout=%h want cnt=%0d o/u=%b%b dout=%h",
                         i, cnt_s, em_s, fu_s, hf_s, ov_s, un_s, dout_s, q.size(), e_ovf, e_unf,
                         (q.size() != 0) ? q[0] : 32'h0);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin
            sel = c;
            case (c)
                0:       begin cur_depth = 16; mask = 32'h0000_00FF; end
                1:       begin cur_depth = 32; mask = 32'h0000_0001; end
                default: begin cur_depth = 2;  mask = 32'hFFFF_FFFF; end
            endcase
            q.delete();
            test_reset();
            test_basic();
            test_fill();
            test_full_rw();
            test_underflow();
            test_underflow_wr();
            test_reset_mid();
            test_random();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
